// File: rtl/mac_seq_pkg.sv
// Shared types and sizing for the MAC FIFO sequencer and its row serializer.
package mac_seq_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int VEC_LEN     = 8;
    localparam int NUM_ROWS    = 8;
    localparam int ACC_WIDTH   = 24;
    localparam int ADDR_WIDTH  = 32;
    localparam int TIMEOUT_CYC = 255;
    localparam int ROW_BITS    = DATA_WIDTH * VEC_LEN;
    localparam int RES_BITS    = NUM_ROWS * ACC_WIDTH;
    localparam int B_ROW_ADDR  = 0;
    localparam int A_BASE_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CLR   = 4'd1,
        ST_REQ   = 4'd2,
        ST_WAIT  = 4'd3,
        ST_PUSH  = 4'd4,
        ST_EXEC  = 4'd5,
        ST_DRAIN = 4'd6,
        ST_CAPT  = 4'd7,
        ST_DONE  = 4'd8
    } seq_state_e;

    // Memory row address -> one-hot A FIFO strobe (row 0 is the B vector, no A bit)
    function automatic logic [NUM_ROWS-1:0] a_row_strobe(input logic [3:0] row);
        logic [NUM_ROWS-1:0] strobe;
        strobe = {NUM_ROWS{1'b0}};
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (row == 4'(i + A_BASE_ADDR)) begin
                strobe[i] = 1'b1;
            end else begin
                strobe[i] = 1'b0;
            end
        end
        return strobe;
    endfunction

endpackage

// File: rtl/row_serializer.sv
// Loads one memory row and emits it byte 0 first, one byte per cycle, with valid/last flags.
module row_serializer
    import mac_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ROW_BITS-1:0]   row_in,
    output logic [DATA_WIDTH-1:0] byte_out,
    output logic                  byte_valid,
    output logic                  byte_last
);

    logic [ROW_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;

    // Load a fresh row, otherwise advance one byte per cycle while bytes remain
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = row_in;
            cnt_d   = 4'(VEC_LEN);
        end else if (cnt_q != 4'd0) begin
            shreg_d = shreg_q >> DATA_WIDTH;
            cnt_d   = cnt_q - 4'd1;
        end else begin
            shreg_d = shreg_q;
            cnt_d   = cnt_q;
        end
        valid_d = (cnt_d != 4'd0);
        last_d  = (cnt_d == 4'd1);
    end

    // Shift register and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= {ROW_BITS{1'b0}};
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign byte_out   = shreg_q[DATA_WIDTH-1:0];
    assign byte_valid = valid_q;
    assign byte_last  = last_q;

endmodule

// File: rtl/mac_fifo_sequencer.sv
// Runs one matrix-vector MAC pass: fetch B and A rows, fill FIFOs, stream into MACs, capture.
// Optional read watchdog enabled by defining SEQ_TIMEOUT_EN.
module mac_fifo_sequencer
    import mac_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    input  logic [ROW_BITS-1:0]   mem_readdata,
    input  logic                  mem_readdatavalid,
    input  logic                  mem_waitrequest,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  b_wren,
    output logic [NUM_ROWS-1:0]   a_wren,
    output logic                  fifo_rden,
    output logic                  mac_clr,
    output logic                  mac_en,
    input  logic [RES_BITS-1:0]   mac_cout,
    output logic [RES_BITS-1:0]   result
);

    seq_state_e            state_q, state_d;
    logic [3:0]            row_q, row_d;
    logic [3:0]            exec_cnt_q, exec_cnt_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  mem_read_q, mem_read_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic                  b_wren_q, b_wren_d;
    logic [NUM_ROWS-1:0]   a_wren_q, a_wren_d;
    logic                  fifo_rden_q, fifo_rden_d;
    logic                  mac_clr_q, mac_clr_d, mac_en_q, mac_en_d;
    logic [RES_BITS-1:0]   result_q, result_d;
    logic                  ser_load_s, ser_valid_s, ser_last_s, start_ok_s, timeout_s;

    row_serializer u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load_s),
        .row_in     (mem_readdata),
        .byte_out   (fifo_wdata),
        .byte_valid (ser_valid_s),
        .byte_last  (ser_last_s)
    );

`ifdef SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       error_q, error_d;

    // Watchdog: consecutive WAIT cycles without read data
    always_comb begin
        wait_cnt_d = 8'd0;
        timeout_s  = 1'b0;
        if (state_q == ST_WAIT && !mem_readdatavalid) begin
            if (wait_cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                timeout_s = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else begin
            wait_cnt_d = 8'd0;
        end
        if (start_ok_s) begin
            error_d = 1'b0;
        end else if (timeout_s) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // Watchdog counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
            error_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            error_q    <= error_d;
        end
    end

    assign error = error_q;
`else
    assign timeout_s = 1'b0;
    assign error     = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        exec_cnt_d = exec_cnt_q;
        ser_load_s = 1'b0;
        start_ok_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_CLR;
                    row_d      = 4'd0;
                    start_ok_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CLR:  state_d = ST_REQ;
            ST_REQ: begin
                if (mem_read_q && !mem_waitrequest) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_readdatavalid) begin
                    state_d    = ST_PUSH;
                    ser_load_s = 1'b1;
                end else if (timeout_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_PUSH: begin
                if (ser_valid_s && ser_last_s) begin
                    row_d      = row_q + 4'd1;
                    exec_cnt_d = 4'd0;
                    state_d    = (row_q == 4'(NUM_ROWS)) ? ST_EXEC : ST_REQ;
                end else begin
                    state_d = ST_PUSH;
                end
            end
            ST_EXEC: begin
                if (exec_cnt_q == 4'(VEC_LEN - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    exec_cnt_d = exec_cnt_q + 4'd1;
                end
            end
            ST_DRAIN: state_d = ST_CAPT;
            ST_CAPT:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are looked ahead from the next state so they can be registered
    always_comb begin
        busy_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
        mem_read_d    = (state_d == ST_REQ);
        mem_address_d = (state_d == ST_REQ) ? {{(ADDR_WIDTH-4){1'b0}}, row_d} : mem_address_q;
        b_wren_d      = (state_d == ST_PUSH) && (row_d == 4'(B_ROW_ADDR));
        a_wren_d      = (state_d == ST_PUSH) ? a_row_strobe(row_d) : {NUM_ROWS{1'b0}};
        fifo_rden_d   = (state_d == ST_EXEC);
        mac_clr_d     = (state_d == ST_CLR);
        mac_en_d      = fifo_rden_q;
        result_d      = (state_q == ST_CAPT) ? mac_cout : result_q;
        if (start_ok_s) begin
            done_d = 1'b0;
        end else if (state_q == ST_CAPT) begin
            done_d = 1'b1;
        end else begin
            done_d = done_q;
        end
    end

    // State, row bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            row_q         <= 4'd0;
            exec_cnt_q    <= 4'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_address_q <= {ADDR_WIDTH{1'b0}};
            b_wren_q      <= 1'b0;
            a_wren_q      <= {NUM_ROWS{1'b0}};
            fifo_rden_q   <= 1'b0;
            mac_clr_q     <= 1'b0;
            mac_en_q      <= 1'b0;
            result_q      <= {RES_BITS{1'b0}};
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            exec_cnt_q    <= exec_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            b_wren_q      <= b_wren_d;
            a_wren_q      <= a_wren_d;
            fifo_rden_q   <= fifo_rden_d;
            mac_clr_q     <= mac_clr_d;
            mac_en_q      <= mac_en_d;
            result_q      <= result_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;
    assign b_wren      = b_wren_q;
    assign a_wren      = a_wren_q;
    assign fifo_rden   = fifo_rden_q;
    assign mac_clr     = mac_clr_q;
    assign mac_en      = mac_en_q;
    assign result      = result_q;

endmodule

// File: tb/tb_mac_fifo_sequencer.sv
// Directed bench for mac_fifo_sequencer with a memory responder and a FIFO+MAC datapath model.
`timescale 1ns/1ps
module tb_mac_fifo_sequencer;

    localparam int AW = 24;
    localparam int NR = 8;
    localparam int RW = NR * AW;

    logic          clk = 1'b0;
    logic          rst_n, start, mem_waitrequest, withhold;
    logic [3:0]    withhold_addr;
    logic          busy, done, error, mem_read, b_wren, fifo_rden, mac_clr, mac_en;
    logic [31:0]   mem_address;
    logic [63:0]   mem_readdata = 64'd0;
    logic          mem_readdatavalid = 1'b0;
    logic [7:0]    fifo_wdata;
    logic [NR-1:0] a_wren;
    logic [RW-1:0] mac_cout = {RW{1'b0}};
    logic [RW-1:0] result;

    logic [63:0]   rows [0:8];
    logic [RW-1:0] exp1, exp2;
    int            total = 0;
    int            bad = 0;
    int            acc4_cnt = 0;
    int            inv_bad = 0;
    int            cyc, acc4_before;
    logic [7:0]    k8;

    always #5 clk = ~clk;

    mac_fifo_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_waitrequest   (mem_waitrequest),
        .fifo_wdata        (fifo_wdata),
        .b_wren            (b_wren),
        .a_wren            (a_wren),
        .fifo_rden         (fifo_rden),
        .mac_clr           (mac_clr),
        .mac_en            (mac_en),
        .mac_cout          (mac_cout),
        .result            (result)
    );

    // Memory: data valid the cycle after an accepted request (unless withheld)
    always @(posedge clk) begin : resp
        logic        acc_s;
        logic [31:0] a_s;
        acc_s = mem_read && !mem_waitrequest && rst_n;
        a_s   = mem_address;
        #1;
        mem_readdatavalid = 1'b0;
        if (acc_s) begin
            if (a_s == 32'd4) acc4_cnt++;
            if (!(withhold && a_s == {28'd0, withhold_addr})) begin
                mem_readdata      = rows[a_s[3:0]];
                mem_readdatavalid = 1'b1;
            end
        end
    end

    // FIFO (read latency 1) and MAC datapath model, plus strobe invariants
    always @(posedge clk) begin : dp
        logic [7:0]    fb [0:15];
        logic [7:0]    fa [0:NR-1][0:15];
        logic [3:0]    bw, br, ar;
        logic [3:0]    aw [0:NR-1];
        logic [7:0]    bout;
        logic [7:0]    aout [0:NR-1];
        logic [AW-1:0] acc [0:NR-1];
        logic          sbw, srd, sclr, sen, srst;
        logic [NR-1:0] saw;
        logic [7:0]    swd;
        sbw = b_wren; saw = a_wren; swd = fifo_wdata; srd = fifo_rden;
        sclr = mac_clr; sen = mac_en; srst = rst_n;
        #1;
        if (!srst) begin
            bw = 4'd0; br = 4'd0; ar = 4'd0; bout = 8'd0;
            for (int r = 0; r < NR; r++) begin
                aw[r] = 4'd0; aout[r] = 8'd0; acc[r] = 24'd0;
            end
        end else begin
            if ((sbw || saw != 8'd0) && srd) inv_bad++;
            if ($countones({sbw, saw}) > 1) inv_bad++;
            for (int r = 0; r < NR; r++) begin
                if (sclr) acc[r] = 24'd0;
                else if (sen) acc[r] = acc[r] + ({16'd0, aout[r]} * {16'd0, bout});
            end
            if (srd) begin
                bout = fb[br]; br = br + 4'd1;
                for (int r = 0; r < NR; r++) aout[r] = fa[r][ar];
                ar = ar + 4'd1;
            end
            if (sbw) begin fb[bw] = swd; bw = bw + 4'd1; end
            for (int r = 0; r < NR; r++) begin
                if (saw[r]) begin fa[r][aw[r]] = swd; aw[r] = aw[r] + 4'd1; end
            end
        end
        for (int r = 0; r < NR; r++) mac_cout[r*AW +: AW] = acc[r];
    end

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0 plain, 1 start pulse in EXEC, 2 waitrequest on row 4, 3 reset during row 3 push
    task automatic run_pass(input int mode, output int n);
        bit inj, bseen, gap;
        int ws, hold;
        n = 0; inj = 1'b0; bseen = 1'b0; gap = 1'b0; ws = 0; hold = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_done_clr", {191'd0, done}, 192'd0);
        check("start_err_clr", {191'd0, error}, 192'd0);
        check("start_busy", {191'd0, busy}, 192'd1);
        while (!done && !error && n < 3000) begin
            if (!busy) gap = 1'b1;
            if (b_wren && !bseen) begin
                bseen = 1'b1;
                check("first_b_byte", {184'd0, fifo_wdata}, {184'd0, rows[0][7:0]});
            end
            if (mode == 1 && !inj && fifo_rden) begin
                start = 1'b1; inj = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (mode == 2) begin
                case (ws)
                    0: if (a_wren[2]) begin mem_waitrequest = 1'b1; ws = 1; end
                    1: if (mem_read) begin
                           check("ws_addr_first", {160'd0, mem_address}, 192'd4);
                           ws = 2; hold = 1;
                       end
                    2: begin
                           check("ws_read_held", {191'd0, mem_read}, 192'd1);
                           check("ws_addr_held", {160'd0, mem_address}, 192'd4);
                           hold++;
                           if (hold == 4) begin mem_waitrequest = 1'b0; ws = 3; end
                       end
                    default: ;
                endcase
            end
            if (mode == 3 && a_wren[2]) begin
                rst_n = 1'b0;
                break;
            end
            @(negedge clk); n++;
        end
        start = 1'b0;
        if (mode != 3) check("busy_gap", {191'd0, gap}, 192'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_waitrequest = 1'b0;
        withhold = 1'b0; withhold_addr = 4'd0;
        for (int r = 0; r < NR; r++) begin
            exp1[r*AW +: AW] = 24'd36;
            exp2[r*AW +: AW] = 24'(16 * (r + 1));
        end
        repeat (3) @(negedge clk);
        check("rst_busy", {191'd0, busy}, 192'd0);
        check("rst_done", {191'd0, done}, 192'd0);
        check("rst_error", {191'd0, error}, 192'd0);
        check("rst_outs", {176'd0, mem_read, b_wren, a_wren, fifo_rden, mac_clr, mac_en, 3'd0},
              192'd0);
        check("rst_addr_wdata", {152'd0, mem_address, fifo_wdata}, 192'd0);
        check("rst_result", result, 192'd0);
        rst_n = 1'b1;

        rows[0] = 64'h0807060504030201;
        for (int k = 1; k <= 8; k++) rows[k] = 64'h0101010101010101;
        run_pass(0, cyc);
        check("p1_cycles", 192'(cyc), 192'd101);
        check("p1_done", {191'd0, done}, 192'd1);
        check("p1_busy", {191'd0, busy}, 192'd0);
        check("p1_result", result, exp1);

        rows[0] = 64'h0202020202020202;
        for (int k = 1; k <= 8; k++) begin
            k8 = 8'(k);
            rows[k] = {8{k8}};
        end
        run_pass(0, cyc);
        check("p2_cycles", 192'(cyc), 192'd101);
        check("p2_result", result, exp2);

        acc4_before = acc4_cnt;
        run_pass(2, cyc);
        check("ws_cycles", 192'(cyc), 192'd104);
        check("ws_one_accept", 192'(acc4_cnt - acc4_before), 192'd1);
        check("ws_result", result, exp2);

        run_pass(1, cyc);
        check("exec_start_cycles", 192'(cyc), 192'd101);
        check("exec_start_result", result, exp2);

        run_pass(3, cyc);
        @(negedge clk);
        check("abort_busy_done", {190'd0, busy, done}, 192'd0);
        check("abort_outs", {176'd0, mem_read, b_wren, a_wren, fifo_rden, mac_clr, mac_en, 3'd0},
              192'd0);
        check("abort_addr_wdata", {152'd0, mem_address, fifo_wdata}, 192'd0);
        check("abort_result", result, 192'd0);
        rst_n = 1'b1;
        run_pass(0, cyc);
        check("after_abort_cycles", 192'(cyc), 192'd101);
        check("after_abort_result", result, exp2);
        check("after_abort_error", {191'd0, error}, 192'd0);

`ifdef SEQ_TIMEOUT_EN
        withhold = 1'b1; withhold_addr = 4'd2;
        run_pass(0, cyc);
        check("to_cycles", 192'(cyc), 192'd277);
        check("to_error", {191'd0, error}, 192'd1);
        check("to_busy_done", {190'd0, busy, done}, 192'd0);
        check("to_result", result, exp2);
        withhold = 1'b0;
        run_pass(0, cyc);
        check("to_rerun_cycles", 192'(cyc), 192'd101);
        check("to_rerun_result", result, exp2);
`endif

        check("strobe_invariants", 192'(inv_bad), 192'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_fifo_sequencer.md
Name: mac_fifo_sequencer

Overview:
- Controller that runs one matrix-vector MAC pass on the 8-lane FIFO+MAC datapath.
- Reads row 0 (B vector) and rows 1..8 (A rows) from mem_wrapper over its read/waitrequest/readdatavalid interface, and serialises each 64-bit row byte-wise into the matching FIFO.
- Then pops all FIFOs in lock-step into the MACs, clears/enables them, and captures the eight accumulated results.
- Sits between the top-level board FSM and the memory/FIFO/MAC instances.

Parameters:
- DATA_WIDTH, 8, byte lane width.
- VEC_LEN, 8, bytes per row and FIFO depth used.
- NUM_ROWS, 8, number of A rows, FIFOs and MACs.
- ACC_WIDTH, 24, MAC accumulator width.
- ADDR_WIDTH, 32, memory address width.
- TIMEOUT_CYC, 255, readdatavalid watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- start  in  1  one-cycle pulse; begins a pass.
- busy  out  1  high from accepted start until done.
- done  out  1  sticky pass-complete flag.
- error  out  1  sticky read-timeout flag.
- mem_address  out  ADDR_WIDTH  row address.
- mem_read  out  1  read request.
- mem_readdata  in  DATA_WIDTH*VEC_LEN  row data.
- mem_readdatavalid  in  1  row data valid.
- mem_waitrequest  in  1  memory busy.
- fifo_wdata  out  DATA_WIDTH  byte to push.
- b_wren  out  1  push to B FIFO.
- a_wren  out  NUM_ROWS  one-hot push to A FIFO r.
- fifo_rden  out  1  pop B and all A FIFOs together.
- mac_clr  out  1  synchronous clear of all MACs.
- mac_en  out  1  accumulate enable for all MACs.
- mac_cout  in  NUM_ROWS*ACC_WIDTH  MAC outputs; lane r at [r*ACC_WIDTH +: ACC_WIDTH].
- result  out  NUM_ROWS*ACC_WIDTH  captured results.

Behaviour:
- Reset: state IDLE; all outputs 0, including result, done, error and mem_address.
- Reset mid-pass aborts immediately. FIFO contents are not this block's concern.
- States: IDLE, CLR, REQ, WAIT, PUSH, EXEC, DRAIN, CAPT, DONE.
- IDLE/DONE + start: go to CLR. Clear done and error. row_idx=0. busy=1.
- start is ignored in every other state.
- CLR: mac_clr=1 for exactly 1 cycle, then REQ.
- REQ: mem_read=1, mem_address=row_idx (row 0 = B, row k = A lane k-1).
  - Address and read stay stable while mem_waitrequest=1.
  - Request is accepted on the first cycle with mem_read & !mem_waitrequest; go to WAIT.
- WAIT: mem_read=0.
  - On mem_readdatavalid, latch mem_readdata into a shift register; go to PUSH.
  - readdatavalid in any other state is ignored.
- PUSH: exactly VEC_LEN cycles.
  - fifo_wdata = byte 0 (bits [7:0]) first, through byte 7.
  - Strobe is b_wren when row_idx==0, else a_wren[row_idx-1].
  - After the last byte: row_idx++. If row_idx was NUM_ROWS go to EXEC, else REQ.
- EXEC: fifo_rden=1 for exactly VEC_LEN cycles (FIFO read latency 1).
- mac_en is fifo_rden delayed 1 cycle, so it is high VEC_LEN cycles. DRAIN is the cycle carrying the last mac_en.
- CAPT: result <= mac_cout (1 cycle after the last mac_en edge); go to DONE.
- DONE: done=1, busy=0. Hold until start or reset.
- Zero-wait pass length: 1 + 9*(1+1+8) + 8 + 1 + 1 = 101 cycles, from start to done.
- Never asserts b_wren/a_wren and fifo_rden in the same cycle.
- At most one wren bit is high at a time.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- When defined: a counter runs in WAIT. If TIMEOUT_CYC cycles pass without readdatavalid:
  - set error;
  - deassert busy;
  - go to DONE with done=0. result is unchanged.
- When undefined: error is tied 0; WAIT waits indefinitely.

Decomposition:
- Package mac_seq_pkg holds:
  - state enum typedef;
  - DATA_WIDTH, VEC_LEN, NUM_ROWS and ACC_WIDTH defaults;
  - B_ROW_ADDR=0 and A_BASE_ADDR=1.
- One natural sub-module: row_serializer. It loads 64 bits and shifts out VEC_LEN bytes with a byte valid and a last flag.

Test Plan:
- Zero-wait memory, B row 0x0807060504030201, all A rows 0x0101010101010101 -> every result lane = 36 (0x24), done at cycle 101, busy low after.
- A row k = k replicated in all bytes, B all 0x02 -> lane k-1 = 16*k (k=8 gives 128).
- mem_waitrequest held 3 cycles on row 4 -> mem_address=4 and mem_read stable those cycles, exactly one accepted request, results unchanged.
- rst_n low during PUSH of row 3 -> all outputs 0 next cycle, state IDLE; a following start completes a correct pass.
- start pulsed during EXEC -> ignored. Second start in DONE -> done clears, full rerun, identical results.
- SEQ_TIMEOUT_EN defined, readdatavalid withheld for row 2 -> error=1 after 255 WAIT cycles, busy=0, done=0.
